// File: rtl/regchain_pkg.sv
// rtl/regchain_pkg.sv - shared constants, BIST state enum and LFSR step for regchain_bank
// Contents: LFSR width/mask/seed, cycle-counter width, err_cnt width, bist_state_e, lfsr_step().
package regchain_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Galois, right-shift: feedback taps applied when the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/regchain_lfsr.sv
// rtl/regchain_lfsr.sv - 16-bit Galois LFSR with seed load and advance enable
// Ports: clk, rst_n (sync, active-low, reloads seed), load (reseed, wins over adv),
//        adv (step once), state (current LFSR value).
module regchain_lfsr
    import regchain_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LFSR_SEED;
        end else if (adv) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/regchain_bank.sv
// rtl/regchain_bank.sv - parametrised bank of shift-register chains with hold, ring and LFSR BIST
// Ports: clk, rst_n (sync, active-low); din[CHANNELS] serial inputs; shift_en, loopback,
//        bist_start controls; dout[CHANNELS] last stages; bist_busy, bist_done status;
//        fail_mask[CHANNELS] sticky mismatch flags; err_cnt[8] saturating mismatch-cycle count.
// Macro REGCHAIN_FAULT_INJECT_EN adds input fault_inj, which inverts channel 0's BIST injection.
module regchain_bank
    import regchain_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 80,
    parameter int BIST_LEN = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic                shift_en,
    input  logic                loopback,
    input  logic                bist_start,
`ifdef REGCHAIN_FAULT_INJECT_EN
    input  logic                fault_inj,
`endif
    output logic [CHANNELS-1:0] dout,
    output logic                bist_busy,
    output logic                bist_done,
    output logic [CHANNELS-1:0] fail_mask,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(BIST_LEN - 1);

    bist_state_e         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CHANNELS-1:0] fail_q;
    logic [ERR_W-1:0]    err_q;
    logic                busy_q;
    logic                done_q;

    logic                start_acc;
    logic                in_check;
    logic                fault_bit;
    logic [LFSR_W-1:0]   gen_state;
    logic [LFSR_W-1:0]   exp_state;
    logic [CHANNELS-1:0] inj;
    logic [CHANNELS-1:0] mism;
    logic                lfsr_unused;

`ifdef REGCHAIN_FAULT_INJECT_EN
    assign fault_bit = fault_inj;
`else
    assign fault_bit = 1'b0;
`endif

    // Requests while busy are dropped; only IDLE/DONE accept a start.
    assign start_acc = bist_start && !busy_q;
    assign in_check  = (state_q == ST_CHECK);

    // gen runs through FILL and CHECK; exp sits on the seed during FILL so its
    // first CHECK value lines up with the first injected pattern reaching dout.
    regchain_lfsr gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .adv   (busy_q),
        .state (gen_state)
    );

    regchain_lfsr exp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .adv   (in_check),
        .state (exp_state)
    );

    // Only the low CHANNELS bits of each LFSR feed the chains.
    assign lfsr_unused = ^{gen_state, exp_state};

    always_comb begin
        inj    = gen_state[CHANNELS-1:0];
        inj[0] = inj[0] ^ fault_bit;
        mism   = in_check ? (dout ^ exp_state[CHANNELS-1:0]) : '0;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chain
        logic [DEPTH-1:0] stage_q;
        logic             in_bit;

        always_comb begin
            in_bit = busy_q ? inj[c] : (loopback ? stage_q[DEPTH-1] : din[c]);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else if (busy_q || shift_en) begin
                stage_q <= {stage_q[DEPTH-2:0], in_bit};
            end
        end

        assign dout[c] = stage_q[DEPTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bist_start) begin
                        state_q <= ST_FILL;
                        cnt_q   <= '0;
                        fail_q  <= '0;
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (cnt_q == FILL_LAST) begin
                        state_q <= ST_CHECK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    fail_q <= fail_q | mism;
                    if ((|mism) && (err_q != {ERR_W{1'b1}})) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    if (cnt_q == CHECK_LAST) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign fail_mask = fail_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_regchain_bank.sv
// tb/tb_regchain_bank.sv - self-checking bench for regchain_bank against a FIFO-and-sequence model
module tb_regchain_bank;

    localparam int CH = 8;
    localparam int D  = 80;
    localparam int L  = 256;

`ifdef REGCHAIN_FAULT_INJECT_EN
    localparam bit FI_EN = 1'b1;
`else
    localparam bit FI_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] din = '0;
    logic          shift_en = 1'b0;
    logic          loopback = 1'b0;
    logic          bist_start = 1'b0;
    logic          fault_inj = 1'b0;
    logic [CH-1:0] dout;
    logic          bist_busy;
    logic          bist_done;
    logic [CH-1:0] fail_mask;
    logic [7:0]    err_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    regchain_bank #(.CHANNELS(CH), .DEPTH(D), .BIST_LEN(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .shift_en   (shift_en),
        .loopback   (loopback),
        .bist_start (bist_start),
`ifdef REGCHAIN_FAULT_INJECT_EN
        .fault_inj  (fault_inj),
`endif
        .dout       (dout),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .fail_mask  (fail_mask),
        .err_cnt    (err_cnt)
    );

    // Reference model: each chain bank is a FIFO of DEPTH words (front = newest,
    // back = dout). A BIST run is tracked by its 1-based cycle number m_k since
    // start; injected word k is pattern seq[k-1], and checked cycle k expects seq[k-1-D].
    logic [CH-1:0] m_pipe[$];
    logic [15:0]   seq[D+L];
    int            m_k = 0;
    bit            m_done = 1'b0;
    logic [CH-1:0] m_fail = '0;
    int            m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic m_push(input logic [CH-1:0] w);
        m_pipe.push_front(w);
        void'(m_pipe.pop_back());
    endtask

    task automatic model_edge();
        logic [CH-1:0] w;
        logic [CH-1:0] mm;
        if (!rst_n) begin
            m_pipe = {};
            for (int i = 0; i < D; i++) m_pipe.push_back('0);
            m_k = 0;
            m_done = 1'b0;
            m_fail = '0;
            m_err = 0;
        end else if (m_k != 0) begin
            w = seq[m_k-1][CH-1:0];
            w[0] = w[0] ^ (fault_inj & FI_EN);
            if (m_k > D) begin
                mm = m_pipe[$] ^ seq[m_k-1-D][CH-1:0];
                m_fail = m_fail | mm;
                if (mm != '0 && m_err < 255) m_err++;
            end
            m_push(w);
            m_k++;
            if (m_k > D + L) begin
                m_k = 0;
                m_done = 1'b1;
            end
        end else begin
            if (shift_en) m_push(loopback ? m_pipe[$] : din);
            if (bist_start) begin
                m_k = 1;
                m_done = 1'b0;
                m_fail = '0;
                m_err = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("dout", 32'(dout), 32'(m_pipe[$]));
        chk("busy", 32'(bist_busy), 32'(m_k != 0));
        chk("done", 32'(bist_done), 32'(m_done));
        chk("fail_mask", 32'(fail_mask), 32'(m_fail));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    // Pulses start at cycle 0 and again at 50 (must be ignored), drives fault_inj
    // over [f_lo, f_hi], randomises normal-mode inputs, and runs until done.
    task automatic run_bist(input int f_lo, input int f_hi, output int busy_n);
        busy_n = 0;
        for (int n = 0; n < 2000; n++) begin
            bist_start = (n == 0) || (n == 50);
            fault_inj  = (n >= f_lo) && (n <= f_hi);
            din        = CH'($urandom);
            shift_en   = 1'($urandom);
            loopback   = 1'($urandom);
            cyc();
            if (bist_busy) busy_n++;
            if (n > 0 && bist_done) break;
        end
        bist_start = 1'b0;
        fault_inj  = 1'b0;
        loopback   = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        int first;
        int width;
        int busy_n;
        int np;
        int other;
        int p[3];

        s = 16'hACE1;
        for (int i = 0; i < D + L; i++) begin
            seq[i] = s;
            s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end
        for (int i = 0; i < D; i++) m_pipe.push_back('0);

        rst_n = 1'b0;
        bist_start = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", 32'(bist_busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        bist_start = 1'b0;
        rst_n = 1'b1;

        first = -1;
        width = 0;
        shift_en = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            din = (n == 1) ? 8'hA5 : 8'h00;
            cyc();
            if (dout == 8'hA5) begin
                if (first < 0) first = n;
                width++;
            end
        end
        chk("shift_latency", 32'(first), 32'd80);
        chk("shift_width", 32'(width), 32'd1);

        first = -1;
        for (int n = 1; n <= 130; n++) begin
            din = (n == 1) ? 8'hFF : 8'h00;
            shift_en = !(n >= 31 && n <= 40);
            cyc();
            if (dout == 8'hFF && first < 0) first = n;
        end
        chk("hold_latency", 32'(first), 32'd90);

        np = 0;
        other = 0;
        p = '{-1, -1, -1};
        shift_en = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            din = (n == 1) ? 8'h08 : 8'h00;
            loopback = (n >= 2);
            cyc();
            if (dout[3]) begin
                if (np < 3) p[np] = n;
                np++;
            end
            if ((dout & 8'hF7) != 8'h00) other++;
        end
        chk("loop_pulses", 32'(np), 32'd3);
        chk("loop_first", 32'(p[0]), 32'd80);
        chk("loop_period1", 32'(p[1] - p[0]), 32'd80);
        chk("loop_period2", 32'(p[2] - p[1]), 32'd80);
        chk("loop_other", 32'(other), 32'd0);
        loopback = 1'b0;

        run_bist(-1, -1, busy_n);
        chk("clean_busy_len", 32'(busy_n), 32'(D + L));
        chk("clean_done", 32'(bist_done), 32'd1);
        chk("clean_fail", 32'(fail_mask), 32'd0);
        chk("clean_err", 32'(err_cnt), 32'd0);

        for (int n = 0; n <= D + 100; n++) begin
            bist_start = (n == 0);
            fault_inj  = (n >= 5 && n <= 20);
            cyc();
        end
        bist_start = 1'b0;
        fault_inj = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(bist_busy), 32'd0);
        chk("midrst_done", 32'(bist_done), 32'd0);
        chk("midrst_fail", 32'(fail_mask), 32'd0);
        chk("midrst_err", 32'(err_cnt), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);

`ifdef REGCHAIN_FAULT_INJECT_EN
        run_bist(10, 12, busy_n);
        chk("fault3_fail", 32'(fail_mask), 32'h01);
        chk("fault3_err", 32'(err_cnt), 32'd3);
        run_bist(1, 300, busy_n);
        chk("fault_sat_fail", 32'(fail_mask), 32'h01);
        chk("fault_sat_err", 32'(err_cnt), 32'd255);
`endif

        for (int n = 0; n < 3000; n++) begin
            din        = CH'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            loopback   = ($urandom_range(0, 7) == 0);
            bist_start = ($urandom_range(0, 299) == 0);
            rst_n      = ($urandom_range(0, 999) != 0);
            fault_inj  = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
